// File: rtl/tcdm16_resp_pkg.sv
// rtl/tcdm16_resp_pkg.sv - shared widths, error pattern and port structs for the TCDM16 bank responder
package tcdm16_resp_pkg;

    localparam int TCDM16_DATA_W = 16;
    localparam int TCDM16_BE_W   = 2;
    localparam int TCDM16_ADDR_W = 32;

    localparam logic [TCDM16_DATA_W-1:0] TCDM16_ERR_PATTERN = 16'hBADD;

    typedef struct packed {
        logic [TCDM16_ADDR_W-1:0] add;
        logic                     wen;
        logic [TCDM16_DATA_W-1:0] wdata;
        logic [TCDM16_BE_W-1:0]   be;
    } tcdm16_req_t;

    typedef struct packed {
        logic [TCDM16_DATA_W-1:0] r_rdata;
        logic                     r_valid;
    } tcdm16_rsp_t;

    function automatic logic [TCDM16_DATA_W-1:0] tcdm16_merge_be(
        input logic [TCDM16_DATA_W-1:0] old_data,
        input logic [TCDM16_DATA_W-1:0] wdata,
        input logic [TCDM16_BE_W-1:0]   be
    );
        return {be[1] ? wdata[15:8] : old_data[15:8],
                be[0] ? wdata[7:0]  : old_data[7:0]};
    endfunction

endpackage

// File: rtl/tcdm16_bank_responder_if.sv
// rtl/tcdm16_bank_responder_if.sv - N-port TCDM16 request/response bundle with master/slave views
interface tcdm16_bank_responder_if
    import tcdm16_resp_pkg::*;
#(
    parameter int N_INIT     = 4,
    parameter int ADDR_WIDTH = 32
);
    logic [N_INIT-1:0]                    req_i;
    logic [N_INIT-1:0][ADDR_WIDTH-1:0]    add_i;
    logic [N_INIT-1:0]                    wen_i;
    logic [N_INIT-1:0][TCDM16_DATA_W-1:0] wdata_i;
    logic [N_INIT-1:0][TCDM16_BE_W-1:0]   be_i;
    logic [N_INIT-1:0]                    gnt_o;
    logic [N_INIT-1:0][TCDM16_DATA_W-1:0] r_rdata_o;
    logic [N_INIT-1:0]                    r_valid_o;

    modport master (
        output req_i, add_i, wen_i, wdata_i, be_i,
        input  gnt_o, r_rdata_o, r_valid_o
    );

    modport slave (
        input  req_i, add_i, wen_i, wdata_i, be_i,
        output gnt_o, r_rdata_o, r_valid_o
    );

endinterface

// File: rtl/tcdm16_rr_arbiter.sv
// rtl/tcdm16_rr_arbiter.sv - combinational round-robin pick: first request at or above rr_q, wrapping
module tcdm16_rr_arbiter #(
    parameter int  N_INIT = 4,
    localparam int IDX_W  = (N_INIT > 1) ? $clog2(N_INIT) : 1
) (
    input  logic [N_INIT-1:0] req,
    input  logic [IDX_W-1:0]  rr_q,
    output logic [N_INIT-1:0] gnt,
    output logic [IDX_W-1:0]  winner,
    output logic              valid
);

    int               sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt    = '0;
        winner = '0;
        valid  = 1'b0;
        sum    = 0;
        idx    = '0;
        for (int i = 0; i < N_INIT; i++) begin
            sum = int'(rr_q) + i;
            if (sum >= N_INIT) begin
                sum = sum - N_INIT;
            end
            idx = IDX_W'(sum);
            if (!valid && req[idx]) begin
                valid    = 1'b1;
                winner   = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcdm16_bank_responder.sv
// rtl/tcdm16_bank_responder.sv - round-robin TCDM16 halfword bank, 1-cycle response; TCDM16_RESP_ADDR_CHECK_EN adds range check
module tcdm16_bank_responder
    import tcdm16_resp_pkg::*;
#(
    parameter int                    N_INIT     = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    BANK_WORDS = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    tcdm16_bank_responder_if.slave   bus,
    output logic                     err_o
);

    localparam int IDX_W  = (N_INIT > 1) ? $clog2(N_INIT) : 1;
    localparam int WORD_W = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;

    logic [IDX_W-1:0]         rr_q;
    logic [IDX_W-1:0]         winner;
    logic [IDX_W-1:0]         rr_next;
    logic                     any_gnt;
    tcdm16_req_t              sel;
    logic [ADDR_WIDTH-1:0]    offset;
    logic [WORD_W-1:0]        word_idx;
    logic                     oor;

    logic [TCDM16_DATA_W-1:0] bank_q [BANK_WORDS];
    logic [TCDM16_DATA_W-1:0] rd_q;

    logic                     rsp_valid_q;
    logic [IDX_W-1:0]         rsp_port_q;
    logic                     rsp_read_q;
    logic                     rsp_bad_q;

    tcdm16_rr_arbiter #(.N_INIT(N_INIT)) u_arb (
        .req    (bus.req_i),
        .rr_q   (rr_q),
        .gnt    (bus.gnt_o),
        .winner (winner),
        .valid  (any_gnt)
    );

    always_comb begin
        sel.add   = TCDM16_ADDR_W'(bus.add_i[winner]);
        sel.wen   = bus.wen_i[winner];
        sel.wdata = bus.wdata_i[winner];
        sel.be    = bus.be_i[winner];
    end

    // BASE_ADDR is aligned to the bank span, so the offset's low bits are the halfword index.
    assign offset   = ADDR_WIDTH'(sel.add) - BASE_ADDR;
    assign word_idx = offset[WORD_W:1];
    assign rr_next  = (winner == IDX_W'(N_INIT - 1)) ? '0 : winner + 1'b1;

`ifdef TCDM16_RESP_ADDR_CHECK_EN
    logic err_q;

    assign oor = offset[0] || (offset >= ADDR_WIDTH'(2 * BANK_WORDS));

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (any_gnt && oor) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_addr_bits;

    assign oor              = 1'b0;
    assign unused_addr_bits = ^{offset[ADDR_WIDTH-1:WORD_W+1], offset[0]};
    assign err_o            = 1'b0;
`endif

    // Bank contents survive reset; only one access per cycle so read and write never collide.
    always_ff @(posedge clk_i) begin
        if (any_gnt) begin
            if (sel.wen) begin
                rd_q <= bank_q[word_idx];
            end else if (!oor) begin
                bank_q[word_idx] <= tcdm16_merge_be(bank_q[word_idx], sel.wdata, sel.be);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= '0;
            rsp_read_q  <= 1'b0;
            rsp_bad_q   <= 1'b0;
            rr_q        <= '0;
        end else begin
            rsp_valid_q <= any_gnt;
            if (any_gnt) begin
                rsp_port_q <= winner;
                rsp_read_q <= sel.wen;
                rsp_bad_q  <= oor;
                rr_q       <= rr_next;
            end
        end
    end

    for (genvar p = 0; p < N_INIT; p++) begin : g_rsp
        tcdm16_rsp_t rsp;

        assign rsp.r_valid = rsp_valid_q && (rsp_port_q == IDX_W'(p));
        assign rsp.r_rdata = (rsp.r_valid && rsp_read_q)
                             ? (rsp_bad_q ? TCDM16_ERR_PATTERN : rd_q) : '0;
        assign bus.r_valid_o[p] = rsp.r_valid;
        assign bus.r_rdata_o[p] = rsp.r_rdata;
    end

endmodule
